// File: rtl/mem_bus_resp_pkg.sv
// Shared types for the execute-side memory responder: FSM states, access
// kinds and the byte-lane selection helper.
package vc16_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        DONE,
        HOLD
    } bus_state_e;

    typedef enum logic [1:0] {
        ACC_FETCH,
        ACC_READ,
        ACC_WRITE
    } acc_e;

    localparam int WAIT_W = 4;

    // Lane 0 is always served before lane 1 when both are pending.
    function automatic logic low_lane(input logic [1:0] mask);
        return ~mask[0];
    endfunction

    function automatic logic [1:0] lane_bit(input logic lane);
        return lane ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_bus_resp_if.sv
// Execute-side request/response bundle. Requests are levels held by execute
// until the matching one-cycle done pulse; execute drops them the cycle after.
interface mem_bus_resp_if #(
    parameter int VA = 16
) ();
    import vc16_bus_pkg::*;

    logic [VA-2:0] pc;
    logic          ifetch;
    logic [VA-2:0] addr;
    logic [1:0]    rstrobe;
    logic [1:0]    wmask;
    logic [15:0]   wdata;
    logic          io_access;
    logic          idone;
    logic          rdone;
    logic          wdone;
    logic [15:0]   ins;
    logic [15:0]   rdata;
    bus_state_e    state;

    modport master (
        output pc, ifetch, addr, rstrobe, wmask, wdata, io_access,
        input  idone, rdone, wdone, ins, rdata, state
    );

    modport slave (
        input  pc, ifetch, addr, rstrobe, wmask, wdata, io_access,
        output idone, rdone, wdone, ins, rdata, state
    );

endinterface

// File: rtl/mem_bus_resp_wait_ctr.sv
// Wait-state down-counter for one external byte strobe. Counting pauses
// while ext_ready is low so a stretch always adds whole cycles.
module bus_wait_ctr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         ready,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (ready && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_bus_resp.sv
// Serialises fetch/read/write requests from execute onto the 8-bit external
// SRAM/IO bus, one byte lane at a time, with programmable wait states.
module mem_bus_resp
    import vc16_bus_pkg::*;
#(
    parameter int RV   = 16,
    parameter int VA   = RV,
    parameter int WAIT = 1
) (
    input  logic          clk,
    input  logic          reset,
    mem_bus_resp_if.slave bus,
    output logic [VA-1:0] ext_addr,
    output logic [7:0]    ext_wdata,
    input  logic [7:0]    ext_rdata,
    output logic          ext_oe,
    output logic          ext_we,
    output logic          ext_io,
    input  logic          ext_ready
);

    if (RV != 16) begin : g_rv_check
        $error("mem_bus_resp: RV must be 16");
    end
    if ((WAIT < 0) || (WAIT > 15)) begin : g_wait_check
        $error("mem_bus_resp: WAIT must be in 0..15");
    end

    localparam logic [WAIT_W-1:0] WAIT_V = WAIT_W'(WAIT);

    bus_state_e    state_q, state_d;
    acc_e          acc_q;
    logic [VA-1:0] base_q;
    logic [1:0]    pend_q;
    logic [1:0]    orig_q;
    logic [15:0]   wdata_q;
    logic [15:0]   hold_q;
    logic          io_q;
    logic          lane_q;
    logic          idone_q, rdone_q, wdone_q;
    logic [15:0]   ins_q, rdata_q;

    logic          any_req;
    logic          lane_sel;
    logic          cnt_zero;
    logic          byte_end;
    logic          last_byte;
    logic [1:0]    pend_left;
    logic [15:0]   merged;

    assign any_req   = (|bus.wmask) | (|bus.rstrobe) | bus.ifetch;
    assign lane_sel  = low_lane(pend_q);
    assign byte_end  = (state_q == STROBE) && cnt_zero && ext_ready;
    assign pend_left = pend_q & ~lane_bit(lane_q);
    assign last_byte = (pend_left == 2'b00);
    // The final byte arrives on the same edge that enters DONE, so merge it
    // here to have ins/rdata valid together with the done pulse.
    assign merged    = lane_q ? {ext_rdata, hold_q[7:0]} : {hold_q[15:8], ext_rdata};

    bus_wait_ctr #(
        .W(WAIT_W)
    ) u_wait_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (state_q == SETUP),
        .load_val (WAIT_V),
        .ready    (ext_ready),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = SETUP;
            SETUP:   state_d = STROBE;
            STROBE:  if (byte_end) state_d = last_byte ? DONE : SETUP;
            DONE:    state_d = HOLD;
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q     <= ACC_FETCH;
            base_q    <= '0;
            pend_q    <= 2'b00;
            orig_q    <= 2'b00;
            wdata_q   <= '0;
            hold_q    <= '0;
            io_q      <= 1'b0;
            lane_q    <= 1'b0;
            ext_addr  <= '0;
            ext_wdata <= '0;
            ext_io    <= 1'b0;
            ext_oe    <= 1'b0;
            ext_we    <= 1'b0;
            idone_q   <= 1'b0;
            rdone_q   <= 1'b0;
            wdone_q   <= 1'b0;
            ins_q     <= '0;
            rdata_q   <= '0;
        end else begin
            ext_oe  <= (state_d == STROBE) && (acc_q != ACC_WRITE);
            ext_we  <= (state_d == STROBE) && (acc_q == ACC_WRITE);
            idone_q <= (state_d == DONE) && (acc_q == ACC_FETCH);
            rdone_q <= (state_d == DONE) && (acc_q == ACC_READ);
            wdone_q <= (state_d == DONE) && (acc_q == ACC_WRITE);

            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        wdata_q <= bus.wdata;
                        io_q    <= bus.io_access;
                        if (|bus.wmask) begin
                            acc_q  <= ACC_WRITE;
                            base_q <= {bus.addr, 1'b0};
                            pend_q <= bus.wmask;
                            orig_q <= bus.wmask;
                        end else if (|bus.rstrobe) begin
                            acc_q  <= ACC_READ;
                            base_q <= {bus.addr, 1'b0};
                            pend_q <= bus.rstrobe;
                            orig_q <= bus.rstrobe;
                        end else begin
                            acc_q  <= ACC_FETCH;
                            base_q <= {bus.pc, 1'b0};
                            pend_q <= 2'b11;
                            orig_q <= 2'b11;
                        end
                    end
                end
                SETUP: begin
                    lane_q    <= lane_sel;
                    ext_addr  <= base_q | {{(VA-1){1'b0}}, lane_sel};
                    ext_io    <= io_q;
                    ext_wdata <= lane_sel ? wdata_q[15:8] : wdata_q[7:0];
                end
                STROBE: begin
                    if (byte_end) begin
                        pend_q <= pend_left;
                        hold_q <= merged;
                        if (last_byte && (acc_q == ACC_FETCH)) begin
                            ins_q <= merged;
                        end
                        // A single-byte read returns that byte in both halves.
                        if (last_byte && (acc_q == ACC_READ)) begin
                            rdata_q <= (orig_q == 2'b11) ? merged : {ext_rdata, ext_rdata};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.idone = idone_q;
    assign bus.rdone = rdone_q;
    assign bus.wdone = wdone_q;
    assign bus.ins   = ins_q;
    assign bus.rdata = rdata_q;
    assign bus.state = state_q;

endmodule
